// File: rtl/mem_seq_if.sv
// Request, response, stack-pointer and memory-port signals of the load/store/stack
// sequencer. "master" is the environment side (CPU decoder plus memory).
// "slave" is the sequencer itself.
interface mem_seq_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) ();
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic              resp_err;
    logic [DATA_W-1:0] resp_data;

    logic              sp_we;
    logic [ADDR_W-1:0] sp_wdata;
    logic [ADDR_W-1:0] sp_out;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_busy;
    logic              mem_ready;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, sp_we, sp_wdata,
               mem_rdata, mem_busy, mem_ready,
        input  req_ready, resp_valid, resp_err, resp_data, sp_out,
               mem_addr, mem_wdata, mem_read, mem_write
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, sp_we, sp_wdata,
               mem_rdata, mem_busy, mem_ready,
        output req_ready, resp_valid, resp_err, resp_data, sp_out,
               mem_addr, mem_wdata, mem_read, mem_write
    );
endinterface

// File: rtl/mem_seq.sv
// Load/store/stack sequencer. It runs one LOAD, STORE, PUSH or POP at a time against a
// busy/ready memory port. It owns the stack pointer, including the overflow and
// underflow checks, and it bounds each memory access with a timeout.
// Every output comes straight from a register or from the state register.
module mem_seq #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] SP_RESET = {ADDR_W{1'b1}},
    parameter logic [ADDR_W-1:0] SP_LIMIT = '0,
    parameter int                TIMEOUT  = 255
) (
    input logic      clk,
    input logic      rst,
    mem_seq_if.slave bus
);
    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    // The counter holds k-1 in the k-th ISSUE/WAIT cycle. Seeing this value means the
    // current cycle is the last one allowed.
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_STORE = 2'd1;
    localparam logic [1:0] OP_PUSH  = 2'd2;
    localparam logic [1:0] OP_POP   = 2'd3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q, state_n;
    logic [1:0]        op_q, op_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [ADDR_W-1:0] sp_q, sp_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic              rd_q, rd_n;
    logic              wr_q, wr_n;
    logic              err_q, err_n;
    logic [DATA_W-1:0] data_q, data_n;

    logic              op_is_rd;
    logic              stack_err;
    logic [ADDR_W-1:0] eff_addr;

    // Decode the incoming request: its effective address and the stack checks, which
    // always use the SP value from before any sp_we in the same cycle.
    always_comb begin
        op_is_rd  = (bus.req_op == OP_LOAD) || (bus.req_op == OP_POP);
        stack_err = ((bus.req_op == OP_PUSH) && (sp_q == SP_LIMIT)) ||
                    ((bus.req_op == OP_POP)  && (sp_q == SP_RESET));
        case (bus.req_op)
            OP_PUSH: eff_addr = sp_q - ADDR_W'(1);
            OP_POP:  eff_addr = sp_q;
            default: eff_addr = bus.req_addr;
        endcase
    end

    // Next-state logic. The strobes default to 0 and are reasserted only where they
    // must stay high.
    always_comb begin
        state_n = state_q;
        op_n    = op_q;
        cnt_n   = cnt_q;
        sp_n    = sp_q;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        rd_n    = 1'b0;
        wr_n    = 1'b0;
        err_n   = err_q;
        data_n  = data_q;

        case (state_q)
            IDLE: begin
                if (bus.sp_we) begin
                    sp_n = bus.sp_wdata;
                end
                if (bus.req_valid) begin
                    op_n    = bus.req_op;
                    wdata_n = bus.req_wdata;
                    addr_n  = eff_addr;
                    cnt_n   = '0;
                    if (stack_err) begin
                        // Overflow/underflow never reaches memory.
                        err_n   = 1'b1;
                        state_n = RESP;
                    end else begin
                        err_n   = 1'b0;
                        rd_n    = op_is_rd;
                        wr_n    = !op_is_rd;
                        state_n = ISSUE;
                    end
                end
            end

            ISSUE: begin
                cnt_n = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    err_n   = 1'b1;
                    state_n = RESP;
                end else if (!bus.mem_busy) begin
                    state_n = WAIT;
                end else begin
                    rd_n = rd_q;
                    wr_n = wr_q;
                end
            end

            WAIT: begin
                cnt_n = cnt_q + CNT_W'(1);
                // Completion wins over a timeout that expires in the same cycle.
                if (bus.mem_ready) begin
                    if ((op_q == OP_LOAD) || (op_q == OP_POP)) begin
                        data_n = bus.mem_rdata;
                    end
                    err_n   = 1'b0;
                    state_n = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    err_n   = 1'b1;
                    state_n = RESP;
                end
            end

            RESP: begin
                if (!err_q) begin
                    if (op_q == OP_PUSH) begin
                        sp_n = addr_q;
                    end else if (op_q == OP_POP) begin
                        sp_n = sp_q + ADDR_W'(1);
                    end
                end
                state_n = IDLE;
            end

            default: state_n = IDLE;
        endcase
    end

    // State and output registers. Reset aborts any transaction and drops the strobes
    // immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_LOAD;
            cnt_q   <= '0;
            sp_q    <= SP_RESET;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_n;
            op_q    <= op_n;
            cnt_q   <= cnt_n;
            sp_q    <= sp_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            rd_q    <= rd_n;
            wr_q    <= wr_n;
            err_q   <= err_n;
            data_q  <= data_n;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_err   = err_q;
    assign bus.resp_data  = data_q;
    assign bus.sp_out     = sp_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_read   = rd_q;
    assign bus.mem_write  = wr_q;
endmodule

// File: tb/tb_mem_seq.sv
// Bench for mem_seq. Each scenario task drives a transaction, pushes its expected
// response onto a scoreboard queue, plays the memory side cycle by cycle and pops the
// expectation when resp_valid appears. Inputs are driven and outputs sampled on the
// falling edge.
`timescale 1ns/1ps
module tb_mem_seq;
    localparam int          DW     = 16;
    localparam int          AW     = 16;
    localparam int          TMO    = 8;
    localparam logic [15:0] SP_RST = 16'hFFFF;
    localparam logic [15:0] SP_LIM = 16'h0000;

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_STORE = 2'd1;
    localparam logic [1:0] OP_PUSH  = 2'd2;
    localparam logic [1:0] OP_POP   = 2'd3;

    logic clk = 1'b0;
    logic rst;

    mem_seq_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mem_seq #(
        .DATA_W(DW), .ADDR_W(AW), .SP_RESET(SP_RST), .SP_LIMIT(SP_LIM), .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [15:0] data;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_mem  [logic [15:0]];
    logic [15:0] tb_mem [logic [15:0]];
    logic [15:0] m_sp;
    logic [15:0] m_last;
    int          n_chk  = 0;
    int          n_pass = 0;

    function automatic logic [15:0] m_get(input logic [15:0] a);
        return m_mem.exists(a) ? m_mem[a] : 16'h0000;
    endfunction

    function automatic logic [15:0] tb_get(input logic [15:0] a);
        return tb_mem.exists(a) ? tb_mem[a] : 16'h0000;
    endfunction

    // One full transaction. A negative rdy_dly means memory never answers.
    task automatic run_txn(input logic [1:0] op, input logic [15:0] addr,
                           input logic [15:0] wdata, input int busy_n, input int rdy_dly,
                           input logic spw, input logic [15:0] spw_val,
                           input logic poke, input string name);
        exp_t        e;
        exp_t        g;
        logic [15:0] ea;
        logic        is_rd, serr, tmo;
        int          rdy_cyc, seen;

        is_rd   = (op == OP_LOAD) || (op == OP_POP);
        ea      = (op == OP_PUSH) ? m_sp - 16'd1 : (op == OP_POP) ? m_sp : addr;
        serr    = ((op == OP_PUSH) && (m_sp == SP_LIM)) || ((op == OP_POP) && (m_sp == SP_RST));
        rdy_cyc = busy_n + 2 + rdy_dly;
        tmo     = !serr && ((rdy_dly < 0) || (rdy_cyc > TMO));
        e.err   = serr || tmo;
        e.lat   = serr ? 1 : (tmo ? TMO + 1 : rdy_cyc + 1);
        e.data  = (is_rd && !e.err) ? m_get(ea) : m_last;
        exp_q.push_back(e);
        if (!is_rd && !e.err) m_mem[ea] = wdata;
        if (spw) m_sp = spw_val;

        n_chk++;
        if (bus.req_ready !== 1'b1)
            $display("FAIL %s req_ready at accept: got %b want 1", name, bus.req_ready);
        else n_pass++;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.sp_we     = spw;
        bus.sp_wdata  = spw_val;

        seen = 0;
        for (int cyc = 1; (cyc <= TMO + 6) && (seen == 0); cyc++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            bus.sp_we     = 1'b0;
            bus.mem_ready = 1'b0;
            bus.mem_busy  = 1'b0;
            bus.mem_rdata = 16'hDEAD;
            if (bus.resp_valid === 1'b1) begin
                seen = cyc;
            end else begin
                n_chk++;
                if ((bus.mem_read !== (is_rd && !serr && cyc <= busy_n + 1)) ||
                    (bus.mem_write !== (!is_rd && !serr && cyc <= busy_n + 1)))
                    $display("FAIL %s strobes cyc %0d: got rd=%b wr=%b", name, cyc,
                             bus.mem_read, bus.mem_write);
                else n_pass++;
                if (!serr) begin
                    n_chk++;
                    if ((bus.mem_addr !== ea) || (!is_rd && bus.mem_wdata !== wdata))
                        $display("FAIL %s addr/wdata cyc %0d: got %h/%h want %h/%h", name, cyc,
                                 bus.mem_addr, bus.mem_wdata, ea, wdata);
                    else n_pass++;
                end
                bus.mem_busy = (cyc <= busy_n);
                if (bus.mem_write && !bus.mem_busy) tb_mem[bus.mem_addr] = bus.mem_wdata;
                if (!tmo && !serr && cyc == rdy_cyc) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = tb_get(ea);
                end
                if (poke && cyc == 1) begin
                    bus.sp_we    = 1'b1;
                    bus.sp_wdata = 16'h5555;
                end
            end
        end

        g = exp_q.pop_front();
        n_chk++;
        if (seen !== g.lat)
            $display("FAIL %s latency: got %0d want %0d", name, seen, g.lat);
        else n_pass++;
        n_chk++;
        if (bus.resp_err !== g.err)
            $display("FAIL %s resp_err: got %b want %b", name, bus.resp_err, g.err);
        else n_pass++;
        n_chk++;
        if (bus.resp_data !== g.data)
            $display("FAIL %s resp_data: got %h want %h", name, bus.resp_data, g.data);
        else n_pass++;
        n_chk++;
        if ((bus.mem_read | bus.mem_write) !== 1'b0)
            $display("FAIL %s strobes during resp: got rd=%b wr=%b", name, bus.mem_read,
                     bus.mem_write);
        else n_pass++;

        if (!g.err && op == OP_PUSH) m_sp = ea;
        if (!g.err && op == OP_POP)  m_sp = m_sp + 16'd1;
        if (is_rd && !g.err) m_last = g.data;

        @(negedge clk);
        n_chk++;
        if (bus.resp_valid !== 1'b0)
            $display("FAIL %s resp_valid width: got %b want 0", name, bus.resp_valid);
        else n_pass++;
        n_chk++;
        if (bus.sp_out !== m_sp)
            $display("FAIL %s sp_out: got %h want %h", name, bus.sp_out, m_sp);
        else n_pass++;
    endtask

    task automatic set_sp(input logic [15:0] v);
        bus.sp_we    = 1'b1;
        bus.sp_wdata = v;
        @(negedge clk);
        bus.sp_we = 1'b0;
        m_sp      = v;
        n_chk++;
        if (bus.sp_out !== v) $display("FAIL set_sp: got %h want %h", bus.sp_out, v);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write} !== 5'b10000)
            $display("FAIL reset ctrl: got rdy/vld/err/rd/wr %b%b%b%b%b want 10000", bus.req_ready,
                     bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write);
        else n_pass++;
        n_chk++;
        if ({bus.resp_data, bus.mem_addr, bus.mem_wdata, bus.sp_out} !== {16'h0, 16'h0, 16'h0, SP_RST})
            $display("FAIL reset data: got %h %h %h %h want 0 0 0 %h", bus.resp_data, bus.mem_addr,
                     bus.mem_wdata, bus.sp_out, SP_RST);
        else n_pass++;
        rst    = 1'b0;
        m_sp   = SP_RST;
        m_last = 16'h0000;
    endtask

    task automatic test_load();
        run_txn(OP_LOAD, 16'h0010, 16'h0000, 0, 0, 1'b0, 16'h0, 1'b0, "load");
    endtask

    task automatic test_push_pop();
        run_txn(OP_PUSH, 16'h0000, 16'h1234, 0, 0, 1'b0, 16'h0, 1'b0, "push");
        run_txn(OP_POP,  16'h0000, 16'h0000, 0, 1, 1'b0, 16'h0, 1'b0, "pop");
    endtask

    task automatic test_stack_err();
        run_txn(OP_POP, 16'h0000, 16'h0000, 0, 0, 1'b0, 16'h0, 1'b0, "underflow");
        set_sp(16'h0000);
        run_txn(OP_PUSH, 16'h0000, 16'h9999, 0, 0, 1'b0, 16'h0, 1'b0, "overflow");
        run_txn(OP_PUSH, 16'h0000, 16'h9999, 0, 0, 1'b1, 16'h0040, 1'b0, "ovf_sp_we");
        run_txn(OP_PUSH, 16'h0000, 16'h7777, 0, 0, 1'b0, 16'h0, 1'b0, "push_low");
        run_txn(OP_POP,  16'h0000, 16'h0000, 0, 0, 1'b0, 16'h0, 1'b0, "pop_low");
        set_sp(SP_RST);
    endtask

    task automatic test_busy_store();
        run_txn(OP_STORE, 16'h0200, 16'hA5A5, 3, 0, 1'b0, 16'h0, 1'b1, "store_busy");
        run_txn(OP_LOAD,  16'h0200, 16'h0000, 1, 2, 1'b0, 16'h0, 1'b0, "load_back");
    endtask

    task automatic test_timeout();
        run_txn(OP_LOAD, 16'h0300, 16'h0000, 0, -1, 1'b0, 16'h0, 1'b0, "tmo_wait");
        run_txn(OP_LOAD, 16'h0010, 16'h0000, 0, TMO - 2, 1'b0, 16'h0, 1'b0, "tmo_edge_ok");
        run_txn(OP_LOAD, 16'h0200, 16'h0000, 10, 0, 1'b0, 16'h0, 1'b0, "tmo_issue");
        run_txn(OP_LOAD, 16'h0010, 16'h0000, 0, 0, 1'b0, 16'h0, 1'b0, "after_tmo");
    endtask

    task automatic test_back_to_back();
        logic [1:0]  op;
        logic [15:0] a, d;
        for (int i = 0; i < 12; i++) begin
            op = ($urandom_range(0, 1) == 0) ? OP_LOAD : OP_STORE;
            a  = 16'h0400 + 16'($urandom_range(0, 5));
            d  = 16'($urandom);
            run_txn(op, a, d, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 16'h0, 1'b0, "b2b");
        end
    endtask

    task automatic test_reset_mid();
        run_txn(OP_PUSH, 16'h0000, 16'h4242, 0, 0, 1'b0, 16'h0, 1'b0, "pre_rst_push");
        bus.req_valid = 1'b1;
        bus.req_op    = OP_LOAD;
        bus.req_addr  = 16'h0010;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.mem_busy  = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({bus.req_ready, bus.resp_valid, bus.mem_read, bus.mem_write} !== 4'b1000)
            $display("FAIL rst_mid ctrl: got rdy/vld/rd/wr %b%b%b%b want 1000", bus.req_ready,
                     bus.resp_valid, bus.mem_read, bus.mem_write);
        else n_pass++;
        n_chk++;
        if ({bus.mem_addr, bus.resp_data, bus.sp_out} !== {16'h0, 16'h0, SP_RST})
            $display("FAIL rst_mid data: got %h %h %h want 0 0 %h", bus.mem_addr, bus.resp_data,
                     bus.sp_out, SP_RST);
        else n_pass++;
        m_sp   = SP_RST;
        m_last = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = 16'h4321;
            @(negedge clk);
            n_chk++;
            if ((bus.resp_valid | bus.mem_read) !== 1'b0)
                $display("FAIL rst_mid quiet cyc %0d: got vld=%b rd=%b want 0", i, bus.resp_valid,
                         bus.mem_read);
            else n_pass++;
        end
        bus.mem_ready = 1'b0;
        run_txn(OP_LOAD, 16'h0010, 16'h0000, 0, 0, 1'b0, 16'h0, 1'b0, "load_after_rst");
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = OP_LOAD;
        bus.req_addr  = 16'h0;
        bus.req_wdata = 16'h0;
        bus.sp_we     = 1'b0;
        bus.sp_wdata  = 16'h0;
        bus.mem_rdata = 16'h0;
        bus.mem_busy  = 1'b0;
        bus.mem_ready = 1'b0;
        tb_mem[16'h0010] = 16'hBEEF;
        m_mem[16'h0010]  = 16'hBEEF;

        test_reset();
        test_load();
        test_push_pop();
        test_stack_err();
        test_busy_store();
        test_timeout();
        test_back_to_back();
        test_reset_mid();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end
endmodule
